soc_system_sysid_checker: RTL and testbench

//   Avalon-MM read master that runs a boot-time check of the system ID peripheral.
//   On start it issues two single-word reads: ID at BASE_ADDR+0, then timestamp at BASE_ADDR+4.
//   It compares both against expected values and reports pass/fail/timeout.

---
 rtl/soc_system_sysid_pkg.sv | 19 +
 rtl/soc_system_sysid_checker.sv | 146 ++++++++++++++
 tb/tb_soc_system_sysid_checker.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_system_sysid_pkg.sv
// Shared types and constants for the boot-time sysid checker.
package soc_system_sysid_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ID_CMD  = 3'd1,
    ST_ID_WAIT = 3'd2,
    ST_TS_CMD  = 3'd3,
    ST_TS_WAIT = 3'd4,
    ST_FIN     = 3'd5
  } state_e;

  localparam logic [31:0] SYSID_ID_OFFSET = 32'd0;
  localparam logic [31:0] SYSID_TS_OFFSET = 32'd4;

  localparam logic [31:0] SYSID_DEF_EXPECTED_ID = 32'hACD5_1302;
  localparam logic [31:0] SYSID_DEF_EXPECTED_TS = 32'h64C5_726D;

endpackage

// File: rtl/soc_system_sysid_checker.sv
// Avalon-MM read master: reads sysid ID and timestamp once per start,
// compares against expected values and reports pass/fail/timeout.
module soc_system_sysid_checker
  import soc_system_sysid_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter logic [31:0]       EXPECTED_ID    = SYSID_DEF_EXPECTED_ID,
  parameter logic [31:0]       EXPECTED_TS    = SYSID_DEF_EXPECTED_TS,
  parameter bit                CHECK_TS       = 1'b1,
  parameter int                TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout_err,
  output logic [31:0]       id_value,
  output logic [31:0]       ts_value
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] ID_ADDR  = BASE_ADDR + ADDR_W'(SYSID_ID_OFFSET);
  localparam logic [ADDR_W-1:0] TS_ADDR  = BASE_ADDR + ADDR_W'(SYSID_TS_OFFSET);
  // Last count value at which a read may still complete; the next step would reach TIMEOUT_CYCLES-1.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_hit, id_match, ts_match;
  logic [ADDR_W-1:0] addr_q;
  logic              read_q, busy_q, done_q, pass_q, id_ok_q, ts_ok_q, to_q;
  logic [31:0]       id_val_q, ts_val_q;

  always_comb begin
    cnt_d    = cnt_q + CNT_W'(1);
    to_hit   = (cnt_q >= CNT_LAST);
    id_match = (avm_readdata == EXPECTED_ID);
    ts_match = CHECK_TS ? (avm_readdata == EXPECTED_TS) : 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      read_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      id_ok_q  <= 1'b0;
      ts_ok_q  <= 1'b0;
      to_q     <= 1'b0;
      id_val_q <= '0;
      ts_val_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            id_ok_q  <= 1'b0;
            ts_ok_q  <= 1'b0;
            pass_q   <= 1'b0;
            to_q     <= 1'b0;
            id_val_q <= '0;
            ts_val_q <= '0;
            busy_q   <= 1'b1;
            read_q   <= 1'b1;
            addr_q   <= ID_ADDR;
            cnt_q    <= '0;
            state_q  <= ST_ID_CMD;
          end
        end
        ST_ID_CMD, ST_TS_CMD: begin
          // Timeout wins over a same-cycle acceptance: the read is abandoned.
          if (to_hit) begin
            read_q  <= 1'b0;
            to_q    <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            cnt_q <= cnt_d;
            if (!avm_waitrequest) begin
              read_q  <= 1'b0;
              state_q <= (state_q == ST_ID_CMD) ? ST_ID_WAIT : ST_TS_WAIT;
            end
          end
        end
        ST_ID_WAIT: begin
          if (avm_readdatavalid) begin
            id_val_q <= avm_readdata;
            id_ok_q  <= id_match;
            read_q   <= 1'b1;
            addr_q   <= TS_ADDR;
            cnt_q    <= '0;
            state_q  <= ST_TS_CMD;
          end else if (to_hit) begin
            to_q    <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_TS_WAIT: begin
          if (avm_readdatavalid) begin
            ts_val_q <= avm_readdata;
            ts_ok_q  <= ts_match;
            state_q  <= ST_FIN;
          end else if (to_hit) begin
            to_q    <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          pass_q  <= id_ok_q & ts_ok_q & ~to_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = to_q;
  assign id_value    = id_val_q;
  assign ts_value    = ts_val_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Bench for the sysid checker: scripted Avalon slave, vector table plus
// randomized runs scored by a duration/outcome model.
module tb_soc_system_sysid_checker;

  localparam int          T    = 8;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] EID  = 32'hACD5_1302;
  localparam logic [31:0] ETS  = 32'h64C5_726D;

  logic        clock, reset, start;
  logic [31:0] avm_address, avm_readdata;
  logic        avm_read, avm_waitrequest, avm_readdatavalid;
  logic        busy, done, pass, id_ok, ts_ok, timeout_err;
  logic [31:0] id_value, ts_value;

  soc_system_sysid_checker #(
    .ADDR_W(32), .BASE_ADDR(BASE), .EXPECTED_ID(EID), .EXPECTED_TS(ETS),
    .CHECK_TS(1'b1), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .pass(pass), .id_ok(id_ok), .ts_ok(ts_ok),
    .timeout_err(timeout_err), .id_value(id_value), .ts_value(ts_value)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Run descriptor: slave behaviour (stall cycles, response latency, 0 = never) and expectations.
  typedef struct {
    logic [31:0] id, ts;
    int s0, l0, s1, l1, rs;
    logic ep, eidok, etsok, eto;
    int elat;
    logic [31:0] eidv, etsv;
  } vec_t;

  function automatic vec_t mk(logic [31:0] id, logic [31:0] ts, int s0, int l0, int s1, int l1, int rs,
                              logic ep, logic eidok, logic etsok, logic eto, int elat,
                              logic [31:0] eidv, logic [31:0] etsv);
    vec_t v;
    v.id = id; v.ts = ts; v.s0 = s0; v.l0 = l0; v.s1 = s1; v.l1 = l1; v.rs = rs;
    v.ep = ep; v.eidok = eidok; v.etsok = etsok; v.eto = eto; v.elat = elat;
    v.eidv = eidv; v.etsv = etsv;
    return v;
  endfunction

  // A read finishes if its data arrives no later than T-2 cycles after it is first
  // presented; it then occupies stall+latency+1 cycles, else T-1 cycles before giving up.
  // Start->done adds one cycle of issue and one of wrap-up.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    bit id_fin, ts_fin;
    id_fin = (v.l0 > 0) && (v.s0 + v.l0 <= T - 2);
    ts_fin = (v.l1 > 0) && (v.s1 + v.l1 <= T - 2);
    r.eidok = 0; r.etsok = 0; r.eto = 0; r.eidv = 0; r.etsv = 0; r.elat = 2;
    if (!id_fin) begin
      r.eto = 1; r.elat += T - 1;
    end else begin
      r.eidv = v.id; r.eidok = (v.id == EID); r.elat += v.s0 + v.l0 + 1;
      if (!ts_fin) begin
        r.eto = 1; r.elat += T - 1;
      end else begin
        r.etsv = v.ts; r.etsok = (v.ts == ETS); r.elat += v.s1 + v.l1 + 1;
      end
    end
    r.ep = r.eidok && r.etsok && !r.eto;
    return r;
  endfunction

  // Number of reads the slave sees accepted (presented with waitrequest low).
  function automatic int exp_reads(vec_t v);
    int n = 0;
    if (v.s0 <= T - 2) n = 1;
    if (n == 1 && v.l0 > 0 && v.s0 + v.l0 <= T - 2 && v.s1 <= T - 2) n = 2;
    return n;
  endfunction

  // ---------------- scripted slave ----------------
  logic [31:0] sl_id, sl_ts, rsp_data, spur_data;
  int          sl_stall[2], sl_lat[2];
  int          rd_idx, stall_left, rsp_cnt;
  bit          spur_req;
  logic [31:0] acc_q[$];

  always @(posedge clock) begin : slave
    logic acc, stalled;
    logic [31:0] a;
    acc     = avm_read && !avm_waitrequest;
    stalled = avm_read && avm_waitrequest;
    a       = avm_address;
    #1;
    if (stalled && avm_read) chk("addr_stable", avm_address, a);
    avm_readdatavalid = 1'b0;
    if (acc) begin
      acc_q.push_back(a);
      if (rd_idx < 2 && sl_lat[rd_idx] > 0) begin
        rsp_cnt  = sl_lat[rd_idx];
        rsp_data = (a == BASE) ? sl_id : sl_ts;
      end
      rd_idx++;
      stall_left = (rd_idx < 2) ? sl_stall[rd_idx] : 0;
    end
    if (rsp_cnt > 0) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = rsp_data;
      end
    end
    if (spur_req) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = spur_data;
      spur_req          = 1'b0;
    end
    if (avm_read && stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else begin
      avm_waitrequest = 1'b0;
    end
  end

  task automatic setup(input vec_t v);
    sl_id = v.id; sl_ts = v.ts;
    sl_stall[0] = v.s0; sl_stall[1] = v.s1;
    sl_lat[0] = v.l0; sl_lat[1] = v.l1;
    rd_idx = 0; stall_left = v.s0; rsp_cnt = 0;
    acc_q.delete();
  endtask

  task automatic run_check(input vec_t v, input string tag);
    int cyc, extra, n;
    setup(v);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; cyc = 1;
    chk({tag, "_busy_start"}, busy, 1);
    while (!done && cyc < 100) begin
      start = (v.rs != 0 && cyc == v.rs);
      @(negedge clock); cyc++;
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_latency"}, cyc, v.elat);
    chk({tag, "_busy_at_done"}, busy, 0);
    chk({tag, "_pass"}, pass, v.ep);
    chk({tag, "_id_ok"}, id_ok, v.eidok);
    chk({tag, "_ts_ok"}, ts_ok, v.etsok);
    chk({tag, "_timeout"}, timeout_err, v.eto);
    chk({tag, "_id_value"}, id_value, v.eidv);
    chk({tag, "_ts_value"}, ts_value, v.etsv);
    n = exp_reads(v);
    chk({tag, "_nreads"}, acc_q.size(), n);
    if (acc_q.size() == n && n >= 1) chk({tag, "_addr_id"}, acc_q[0], BASE);
    if (acc_q.size() == n && n == 2) chk({tag, "_addr_ts"}, acc_q[1], BASE + 32'd4);
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done) extra++;
    end
    chk({tag, "_extra_done"}, extra, 0);
    chk({tag, "_busy_after"}, busy, 0);
    chk({tag, "_pass_held"}, pass, v.ep);
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    int cyc;
    start = 1'b0; reset = 1'b0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    spur_req = 1'b0; spur_data = '0; rsp_cnt = 0; rd_idx = 2; stall_left = 0;
    sl_stall[0] = 0; sl_stall[1] = 0; sl_lat[0] = 0; sl_lat[1] = 0;
    #2 reset = 1'b1;
    @(negedge clock); @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, BASE);
    chk("rst_pass", pass, 0);
    chk("rst_id_value", id_value, 0);
    reset = 1'b0;
    @(negedge clock);

    //             id            ts            s0 l0 s1 l1 rs  ep eid ets eto lat idv           tsv
    tbl[0] = mk(EID,          ETS,          0, 1, 0, 1, 0, 1, 1, 1, 0, 6,  EID,          ETS);
    tbl[1] = mk(32'hACD51303, ETS,          0, 1, 0, 1, 0, 0, 0, 1, 0, 6,  32'hACD51303, ETS);
    tbl[2] = mk(EID,          ETS,          5, 1, 5, 1, 0, 1, 1, 1, 0, 16, EID,          ETS);
    tbl[3] = mk(EID,          ETS,          0, 1, 0, 0, 0, 0, 1, 0, 1, 11, EID,          32'h0);
    tbl[4] = mk(EID,          ETS,          6, 1, 0, 1, 0, 0, 0, 0, 1, 9,  32'h0,        32'h0);
    tbl[5] = mk(EID,          ETS,          0, 1, 0, 6, 0, 1, 1, 1, 0, 11, EID,          ETS);
    tbl[6] = mk(EID,          ETS,          0, 1, 0, 7, 0, 0, 1, 0, 1, 11, EID,          32'h0);
    tbl[7] = mk(EID,          32'h64C5726C, 2, 3, 1, 2, 0, 0, 1, 0, 0, 12, EID,          32'h64C5726C);
    tbl[8] = mk(EID,          ETS,          0, 1, 0, 1, 2, 1, 1, 1, 0, 6,  EID,          ETS);
    tbl[9] = mk(EID,          ETS,          0, 1, 0, 1, 5, 1, 1, 1, 0, 6,  EID,          ETS);
    for (int i = 0; i < 10; i++) run_check(tbl[i], $sformatf("vec%0d", i));

    // spurious readdatavalid while idle must not disturb held status
    spur_data = 32'hDEAD_BEEF; spur_req = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clock);
    chk("spur_id_value", id_value, EID);
    chk("spur_ts_value", ts_value, ETS);
    chk("spur_busy", busy, 0);
    chk("spur_pass", pass, 1);

    // start on the cycle right after done is accepted
    setup(tbl[0]);
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0; cyc = 1;
    while (!done && cyc < 100) begin @(negedge clock); cyc++; end
    chk("b2b_first_done", done, 1);
    setup(tbl[0]);
    start = 1'b1;
    @(negedge clock); start = 1'b0; cyc = 1;
    chk("b2b_busy", busy, 1);
    while (!done && cyc < 100) begin @(negedge clock); cyc++; end
    chk("b2b_latency", cyc, 6);
    chk("b2b_pass", pass, 1);
    for (int i = 0; i < 3; i++) @(negedge clock);

    // reset during the timestamp wait, then a late response after release
    setup(mk(EID, ETS, 0, 1, 0, 6, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0));
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clock);
    chk("rstmid_pre_id_ok", id_ok, 1);
    chk("rstmid_pre_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_id_ok", id_ok, 0);
    chk("rstmid_id_value", id_value, 0);
    chk("rstmid_read", avm_read, 0);
    chk("rstmid_addr", avm_address, BASE);
    @(negedge clock); reset = 1'b0;
    for (int i = 0; i < 8; i++) @(negedge clock);
    chk("rstmid_late_ts_value", ts_value, 0);
    chk("rstmid_late_busy", busy, 0);
    chk("rstmid_late_done", done, 0);
    run_check(tbl[0], "after_rst");

    // randomized runs scored by the model
    for (int i = 0; i < 24; i++) begin
      rv.id = ($urandom_range(0, 2) == 0) ? $urandom : EID;
      rv.ts = ($urandom_range(0, 2) == 0) ? $urandom : ETS;
      rv.s0 = $urandom_range(0, 6); rv.l0 = $urandom_range(0, 7);
      rv.s1 = $urandom_range(0, 6); rv.l1 = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 0) begin
        rv.l0 = $urandom_range(1, 2); rv.s0 = $urandom_range(0, 2);
      end
      rv.rs = $urandom_range(0, 4);
      rv = model(rv);
      run_check(rv, $sformatf("rnd%0d", i));
      for (int k = 0; k < 6; k++) @(negedge clock);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
